// File: rtl/maze_ram_writer.sv
// Write port of the maze cell RAM: bulk ROM->RAM level copy plus single-cell valid/ready writes.
// Optional MAZE_WR_BOUNDS_CHECK_EN: out-of-range requests are consumed without a write and pulse err.
module maze_ram_writer #(
    parameter int XSIZE      = 24,
    parameter int YSIZE      = 24,
    parameter int ROW_STRIDE = 32,
    parameter int DATA_W     = 3,
    parameter int ADDR_W     = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_copy,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [4:0]        req_x,
    input  logic [4:0]        req_y,
    input  logic [DATA_W-1:0] req_data,
    output logic [ADDR_W-1:0] rom_address,
    input  logic [DATA_W-1:0] rom_q,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int         STRIDE_SH = $clog2(ROW_STRIDE);
    localparam logic [4:0] X_LAST    = 5'(XSIZE - 1);
    localparam logic [4:0] Y_LAST    = 5'(YSIZE - 1);

    typedef enum logic [1:0] {IDLE, COPY, DRAIN, DONE} state_t;

    state_t              state, state_next;
    logic [4:0]          x, y;
    logic                accept, copy_last;
    logic                issue_v, wr_from_rom, wren_q, busy_q, done_q;
    logic [ADDR_W-1:0]   rom_addr_q, ram_addr_q;
    logic [DATA_W-1:0]   data_q;

    // Same mapping as the display-side reader: x + y * ROW_STRIDE, truncated.
    function automatic logic [ADDR_W-1:0] cell_addr(input logic [4:0] cx, input logic [4:0] cy);
        return ADDR_W'(cx) + (ADDR_W'(cy) << STRIDE_SH);
    endfunction

    // Handshake: a request transfers on a rising edge where req_valid && req_ready;
    // req_ready is high only in IDLE and drops combinationally while start_copy is high.
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        accept     = 1'b0;
        copy_last  = (x == X_LAST) && (y == Y_LAST);
        case (state)
            IDLE: begin
                req_ready = !start_copy;
                accept    = req_valid && !start_copy;
                if (start_copy) state_next = COPY;
            end
            COPY:    if (copy_last) state_next = DRAIN;
            DRAIN:   state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

`ifdef MAZE_WR_BOUNDS_CHECK_EN
    logic oob, err_q;
    assign oob = (req_x > X_LAST) || (req_y > Y_LAST);
    always_ff @(posedge clk) begin
        if (reset) err_q <= 1'b0;
        else       err_q <= accept && oob;
    end
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            x           <= '0;
            y           <= '0;
            issue_v     <= 1'b0;
            wr_from_rom <= 1'b0;
            wren_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rom_addr_q  <= '0;
            ram_addr_q  <= '0;
            data_q      <= '0;
        end else begin
            issue_v     <= (state == COPY);
            busy_q      <= (state == COPY) || (state == DRAIN);
            done_q      <= (state == DONE);
            wren_q      <= 1'b0;
            wr_from_rom <= 1'b0;

            // Copy writes trail the ROM address by one cycle, matching ROM read latency.
            if (issue_v) begin
                wren_q      <= 1'b1;
                wr_from_rom <= 1'b1;
                ram_addr_q  <= rom_addr_q;
            end else if (accept) begin
`ifdef MAZE_WR_BOUNDS_CHECK_EN
                wren_q      <= !oob;
`else
                wren_q      <= 1'b1;
`endif
                ram_addr_q  <= cell_addr(req_x, req_y);
                data_q      <= req_data;
            end

            if (state == IDLE && start_copy) begin
                x <= '0;
                y <= '0;
            end else if (state == COPY) begin
                rom_addr_q <= cell_addr(x, y);
                if (copy_last) begin
                    x <= '0;
                    y <= '0;
                end else if (x == X_LAST) begin
                    x <= '0;
                    y <= y + 5'd1;
                end else begin
                    x <= x + 5'd1;
                end
            end
        end
    end

    // ROM data arrives in the same cycle the delayed address is presented, so it bypasses data_q.
    assign ram_data    = wr_from_rom ? rom_q : data_q;
    assign ram_wren    = wren_q;
    assign ram_address = ram_addr_q;
    assign rom_address = rom_addr_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_maze_ram_writer.sv
// Self-checking bench for maze_ram_writer: single-cell vector table plus copy/reset sequences.
module tb_maze_ram_writer;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 3;
`ifdef MAZE_WR_BOUNDS_CHECK_EN
    localparam bit BC = 1'b1;
`else
    localparam bit BC = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              start_copy;
    logic              req_valid;
    logic              req_ready;
    logic [4:0]        req_x;
    logic [4:0]        req_y;
    logic [DATA_W-1:0] req_data;
    logic [ADDR_W-1:0] rom_address;
    logic [DATA_W-1:0] rom_q;
    logic [ADDR_W-1:0] ram_address;
    logic [DATA_W-1:0] ram_data;
    logic              ram_wren;
    logic              busy;
    logic              done;
    logic              err;

    int n_tests = 0;
    int n_fail  = 0;
    logic [ADDR_W-1:0] exp_q[$];

    typedef struct {
        logic       v;
        logic [4:0] x;
        logic [4:0] y;
        logic [2:0] d;
        int         exp_addr;
    } vec_t;

    vec_t vecs[8];

    maze_ram_writer dut (
        .clk(clk), .reset(reset), .start_copy(start_copy),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_x(req_x), .req_y(req_y), .req_data(req_data),
        .rom_address(rom_address), .rom_q(rom_q),
        .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Source ROM model: rom[a] = a[2:0], one cycle read latency.
    always @(posedge clk) rom_q <= rom_address[2:0];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_copy(input bit with_req);
        int done_cnt = 0, done_edge = -1, first_wr = -1, last_wr = -1;
        int nwr = 0, busy_bad = 0, req_edge = -1;
        bit req_seen = 1'b0;
        bit acc;
        logic [ADDR_W-1:0] e;
        exp_q.delete();
        for (int yy = 0; yy < 24; yy++)
            for (int xx = 0; xx < 24; xx++) begin
                e = ADDR_W'(xx + yy * 32);
                exp_q.push_back(e);
            end
        start_copy = 1'b1;
        if (with_req) begin
            req_valid = 1'b1; req_x = 5'd5; req_y = 5'd1; req_data = 3'd4;
        end
        #1;
        if (with_req) check("ready_low_with_start", req_ready, 0);
        tick();
        start_copy = 1'b0;
        for (int k = 1; k <= 590; k++) begin
            acc = req_valid && req_ready;
            tick();
            if (acc) begin
                req_valid = 1'b0;
                req_edge = k;
            end
            if (k == 1) check("rom_addr_first", rom_address, 0);
            if (k == 100) check("ready_low_in_copy", req_ready, 0);
            if (busy !== (k <= 577)) busy_bad++;
            if (done === 1'b1) begin
                done_cnt++;
                done_edge = k;
            end
            if (ram_wren === 1'b1) begin
                if (acc) begin
                    req_seen = 1'b1;
                    check("req_after_copy_addr", ram_address, 37);
                    check("req_after_copy_data", ram_data, 4);
                end else begin
                    if (first_wr < 0) first_wr = k;
                    last_wr = k;
                    nwr++;
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("copy_wr_addr", ram_address, e);
                        check("copy_wr_data", ram_data, e[2:0]);
                    end
                end
            end
        end
        check("copy_write_count", nwr, 576);
        check("copy_first_wr_edge", first_wr, 2);
        check("copy_last_wr_edge", last_wr, 577);
        check("copy_done_count", done_cnt, 1);
        check("copy_done_edge", done_edge, 578);
        check("copy_busy_window_errors", busy_bad, 0);
        if (with_req) begin
            check("req_accept_edge", req_edge, 579);
            check("req_write_seen", req_seen, 1);
        end
    endtask

    initial begin
        bit oob, exp_wren, exp_err;
        int done_seen;

        vecs[0] = '{1'b1, 5'd3,  5'd2,  3'd5, 67};
        vecs[1] = '{1'b1, 5'd0,  5'd0,  3'd7, 0};
        vecs[2] = '{1'b1, 5'd23, 5'd23, 3'd2, 759};
        vecs[3] = '{1'b0, 5'd9,  5'd9,  3'd1, 0};
        vecs[4] = '{1'b1, 5'd10, 5'd5,  3'd3, 170};
        vecs[5] = '{1'b1, 5'd24, 5'd0,  3'd6, 24};
        vecs[6] = '{1'b1, 5'd31, 5'd31, 3'd1, 1023};
        vecs[7] = '{1'b1, 5'd1,  5'd1,  3'd0, 33};

        reset = 1'b1; start_copy = 1'b0; req_valid = 1'b0;
        req_x = '0; req_y = '0; req_data = '0;
        repeat (3) tick();
        reset = 1'b0;
        repeat (5) tick();
        check("rst_wren", ram_wren, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_ready", req_ready, 1);
        check("rst_rom_addr", rom_address, 0);
        check("rst_ram_addr", ram_address, 0);

        // Back-to-back single-cell writes: one vector per cycle.
        for (int i = 0; i < 8; i++) begin
            req_valid = vecs[i].v; req_x = vecs[i].x; req_y = vecs[i].y; req_data = vecs[i].d;
            oob      = (vecs[i].x >= 5'd24) || (vecs[i].y >= 5'd24);
            exp_wren = vecs[i].v && !(BC && oob);
            exp_err  = vecs[i].v && BC && oob;
            #1;
            check($sformatf("vec%0d_ready", i), req_ready, 1);
            tick();
            check($sformatf("vec%0d_wren", i), ram_wren, exp_wren);
            check($sformatf("vec%0d_err", i), err, exp_err);
            if (exp_wren) begin
                check($sformatf("vec%0d_addr", i), ram_address, vecs[i].exp_addr);
                check($sformatf("vec%0d_data", i), ram_data, vecs[i].d);
            end
        end
        req_valid = 1'b0;
        tick();
        check("idle_after_vecs_wren", ram_wren, 0);
        check("idle_after_vecs_err", err, 0);

        do_copy(1'b0);
        do_copy(1'b1);

        // Reset in the middle of a copy.
        start_copy = 1'b1;
        tick();
        start_copy = 1'b0;
        repeat (300) tick();
        check("midcopy_wren_before_reset", ram_wren, 1);
        reset = 1'b1;
        tick();
        check("midcopy_reset_wren", ram_wren, 0);
        check("midcopy_reset_busy", busy, 0);
        check("midcopy_reset_done", done, 0);
        check("midcopy_reset_ready", req_ready, 1);
        reset = 1'b0;
        done_seen = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (done === 1'b1 || ram_wren === 1'b1) done_seen++;
        end
        check("midcopy_no_done_or_write", done_seen, 0);

        do_copy(1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
